// File: rtl/fp_matrix_loader_if.sv
// rtl/fp_matrix_loader_if.sv - element stream bundle feeding the matrix loader
interface fp_matrix_loader_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/fp_matrix_loader.sv
// rtl/fp_matrix_loader.sv - row-major stream to parallel operand arrays for the fp matrix multiplier
module fp_matrix_loader #(
    parameter int WIDTH = 32,
    parameter int ROWS1 = 4,
    parameter int INNER = 5,
    parameter int COLS2 = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    fp_matrix_loader_if.slave                        s_in,
    input  logic                                     mult_done,
    output logic [ROWS1-1:0][INNER-1:0][WIDTH-1:0]   Matrix1,
    output logic [INNER-1:0][COLS2-1:0][WIDTH-1:0]   Matrix2,
    output logic                                     start,
    output logic                                     frame_err,
    output logic                                     busy
);
    localparam int MAXD = (ROWS1 > INNER) ? ((ROWS1 > COLS2) ? ROWS1 : COLS2)
                                          : ((INNER > COLS2) ? INNER : COLS2);
    localparam int CW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                                 r_state, w_next_state;
    logic [CW-1:0]                          r_row, r_col, w_next_row, w_next_col;
    logic                                   r_frame_err, w_next_err;
    logic [ROWS1-1:0][INNER-1:0][WIDTH-1:0] r_m1;
    logic [INNER-1:0][COLS2-1:0][WIDTH-1:0] r_m2;
    logic                                   w_in_ready, w_accept;
    logic                                   w_row_end_a, w_col_end_a, w_row_end_b, w_col_end_b, w_final_b;

    assign w_in_ready  = (r_state != RUN);
    assign w_accept    = s_in.in_valid && w_in_ready;
    assign w_row_end_a = (r_row == CW'(ROWS1-1));
    assign w_col_end_a = (r_col == CW'(INNER-1));
    assign w_row_end_b = (r_row == CW'(INNER-1));
    assign w_col_end_b = (r_col == CW'(COLS2-1));
    assign w_final_b   = w_row_end_b && w_col_end_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD_A;
            r_row       <= '0;
            r_col       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_row       <= w_next_row;
            r_col       <= w_next_col;
            r_frame_err <= w_next_err;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_col   = r_col;
        w_next_err   = 1'b0;
        unique case (r_state)
            LOAD_A: begin
                if (w_accept) begin
                    // in_last can only ever be legal on the final matrix2 element
                    if (s_in.in_last) begin
                        w_next_err = 1'b1;
                        w_next_row = '0;
                        w_next_col = '0;
                    end else if (w_col_end_a) begin
                        w_next_col = '0;
                        if (w_row_end_a) begin
                            w_next_row   = '0;
                            w_next_state = LOAD_B;
                        end else begin
                            w_next_row = r_row + 1'b1;
                        end
                    end else begin
                        w_next_col = r_col + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (w_accept) begin
                    if (s_in.in_last != w_final_b) begin
                        w_next_err   = 1'b1;
                        w_next_row   = '0;
                        w_next_col   = '0;
                        w_next_state = LOAD_A;
                    end else if (w_final_b) begin
                        w_next_row   = '0;
                        w_next_col   = '0;
                        w_next_state = RUN;
                    end else if (w_col_end_b) begin
                        w_next_col = '0;
                        w_next_row = r_row + 1'b1;
                    end else begin
                        w_next_col = r_col + 1'b1;
                    end
                end
            end
            RUN: begin
                if (mult_done) begin
                    w_next_state = LOAD_A;
                end
            end
            default: begin
                w_next_state = LOAD_A;
                w_next_row   = '0;
                w_next_col   = '0;
            end
        endcase
    end

    // The offending element of a bad frame is still stored; only the frame is abandoned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m1 <= '0;
            r_m2 <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < ROWS1; r++) begin
                for (int c = 0; c < INNER; c++) begin
                    if (r_state == LOAD_A && r_row == CW'(r) && r_col == CW'(c)) begin
                        r_m1[r][c] <= s_in.in_data;
                    end
                end
            end
            for (int r = 0; r < INNER; r++) begin
                for (int c = 0; c < COLS2; c++) begin
                    if (r_state == LOAD_B && r_row == CW'(r) && r_col == CW'(c)) begin
                        r_m2[r][c] <= s_in.in_data;
                    end
                end
            end
        end
    end

    assign s_in.in_ready = w_in_ready;
    assign Matrix1       = r_m1;
    assign Matrix2       = r_m2;
    assign start         = (r_state == RUN);
    assign busy          = (r_state != LOAD_A);
    assign frame_err     = r_frame_err;
endmodule

// File: tb/tb_fp_matrix_loader.sv
// tb/tb_fp_matrix_loader.sv - self-checking bench for fp_matrix_loader
module tb_fp_matrix_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mult_done = 1'b0;
    logic [3:0][4:0][31:0] m1_o;
    logic [4:0][2:0][31:0] m2_o;
    logic start, frame_err, busy;
    int checks = 0;
    int failures = 0;

    fp_matrix_loader_if #(.WIDTH(32)) bus ();

    fp_matrix_loader #(.WIDTH(32), .ROWS1(4), .INNER(5), .COLS2(3)) dut (
        .clk(clk), .rst_n(rst_n), .s_in(bus.slave), .mult_done(mult_done),
        .Matrix1(m1_o), .Matrix2(m2_o), .start(start), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a flat element index into the 35-element frame
    int          m_k;
    bit          m_run, m_err;
    logic [31:0] exp_m1 [4][5];
    logic [31:0] exp_m2 [5][3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k = 0; m_run = 0; m_err = 0;
            for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) exp_m1[r][c] = '0;
            for (int r = 0; r < 5; r++) for (int c = 0; c < 3; c++) exp_m2[r][c] = '0;
        end else begin
            m_err = 0;
            if (m_run) begin
                if (mult_done) m_run = 0;
            end else if (bus.in_valid) begin
                if (m_k < 20) exp_m1[m_k / 5][m_k % 5] = bus.in_data;
                else          exp_m2[(m_k - 20) / 3][(m_k - 20) % 3] = bus.in_data;
                if (bus.in_last != (m_k == 34)) begin
                    m_err = 1; m_k = 0;
                end else if (m_k == 34) begin
                    m_run = 1; m_k = 0;
                end else begin
                    m_k++;
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic ctl_check();
        chk("in_ready", 32'(bus.in_ready), 32'(!m_run));
        chk("start", 32'(start), 32'(m_run));
        chk("busy", 32'(busy), 32'(m_run || (m_k >= 20)));
        chk("frame_err", 32'(frame_err), 32'(m_err));
    endtask

    task automatic step(bit v, logic [31:0] d, bit l, bit done);
        @(negedge clk);
        ctl_check();
        bus.in_valid = v; bus.in_data = d; bus.in_last = l; mult_done = done;
    endtask

    task automatic arrays_check();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) chk("matrix1", m1_o[r][c], exp_m1[r][c]);
        for (int r = 0; r < 5; r++) for (int c = 0; c < 3; c++) chk("matrix2", m2_o[r][c], exp_m2[r][c]);
    endtask

    task automatic arrays_zero(string name);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) chk(name, m1_o[r][c], 32'h0);
        for (int r = 0; r < 5; r++) for (int c = 0; c < 3; c++) chk(name, m2_o[r][c], 32'h0);
    endtask

    // kind: 0 = directed operands, 1 = all 1.0f, 2 = random; bub: 0 none, 1 alternate, 2 random
    typedef struct {
        int kind;
        int last_pos;
        int bub;
        bit exp_start;
        bit exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(vec_t v);
        logic [31:0] frame [35];
        logic [31:0] a0 [5];
        logic [31:0] b0 [3];
        int n;
        a0 = '{32'h40066666, 32'hbf800000, 32'h3e99999a, 32'h4059999a, 32'hc0866666};
        b0 = '{32'h400ccccd, 32'h40133333, 32'h404ccccd};
        for (int i = 0; i < 35; i++) frame[i] = (v.kind == 1) ? 32'h3f800000 : $urandom;
        if (v.kind == 0) begin
            for (int i = 0; i < 5; i++) frame[i] = a0[i];
            for (int i = 0; i < 3; i++) frame[20 + i] = b0[i];
        end
        n = (v.last_pos >= 0) ? v.last_pos + 1 : 35;
        for (int i = 0; i < n; i++) begin
            if (v.bub == 1 && i > 0) step(0, $urandom, 0, 0);
            if (v.bub == 2 && $urandom_range(0, 2) == 0)
                step(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step(1, frame[i], (i == v.last_pos), 0);
        end
        step(0, 32'h0, 0, 0);
        chk("vec_start", 32'(start), 32'(v.exp_start));
        chk("vec_frame_err", 32'(frame_err), 32'(v.exp_err));
        chk("vec_in_ready", 32'(bus.in_ready), 32'(!v.exp_start));
        arrays_check();
        if (v.kind == 0 && v.exp_start) begin
            chk("m1_0_4", m1_o[0][4], 32'hc0866666);
            chk("m2_0_2", m2_o[0][2], 32'h404ccccd);
        end
        if (v.kind == 1) chk("ones_m2_4_2", m2_o[4][2], 32'h3f800000);
        if (v.exp_start) begin
            step(1, $urandom, 1, 0);
            step(0, 32'h0, 0, 0);
            arrays_check();
            step(0, 32'h0, 0, 1);
            step(0, 32'h0, 0, 0);
            chk("done_start", 32'(start), 32'h0);
            chk("done_in_ready", 32'(bus.in_ready), 32'h1);
        end
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
        vecs[0] = '{0, 34, 0, 1'b1, 1'b0};
        vecs[1] = '{0, 34, 1, 1'b1, 1'b0};
        vecs[2] = '{1, 34, 0, 1'b1, 1'b0};
        vecs[3] = '{2, 9, 0, 1'b0, 1'b1};
        vecs[4] = '{2, 34, 1, 1'b1, 1'b0};
        vecs[5] = '{2, -1, 0, 1'b0, 1'b1};
        vecs[6] = '{2, 34, 2, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        arrays_zero("rst_array");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while loading matrix2
        for (int i = 0; i < 25; i++) step(1, $urandom, 0, 0);
        step(0, 32'h0, 0, 0);
        chk("mid_b_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstb_start", 32'(start), 32'h0);
        chk("rstb_busy", 32'(busy), 32'h0);
        arrays_zero("rstb_array");
        @(negedge clk) rst_n = 1'b1;
        step(0, 32'h0, 0, 0);
        chk("rstb_in_ready", 32'(bus.in_ready), 32'h1);

        // Reset while the multiplier runs
        for (int i = 0; i < 35; i++) step(1, $urandom, (i == 34), 0);
        step(0, 32'h0, 0, 0);
        chk("run_start", 32'(start), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstr_start", 32'(start), 32'h0);
        chk("rstr_busy", 32'(busy), 32'h0);
        arrays_zero("rstr_array");
        @(negedge clk) rst_n = 1'b1;
        step(0, 32'h0, 0, 0);
        chk("rstr_in_ready", 32'(bus.in_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
